gcn_result_streamer: RTL

Downstream stage of the GCN top level. Captures the per-node argmax class vector when the GCN raises `done` and streams it out one node per beat over a valid/ready interface. Accumulates a per-frame class histogram and publishes it at end of frame. Decouples the parallel GCN result from a narrow host/DMA sink and flags results lost to back-pressure.

---
 rtl/gcn_pkg.sv | 12 +
 rtl/gcn_class_hist.sv | 48 ++++
 rtl/gcn_result_streamer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gcn_pkg.sv
// Shared GCN defaults and the result-streamer state encoding.
package gcn_pkg;

    localparam int unsigned FEATURE_ROWS_DEF      = 6;
    localparam int unsigned MAX_ADDRESS_WIDTH_DEF = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

endpackage

// File: rtl/gcn_class_hist.sv
// Per-frame class histogram: working counters plus the published copy seen by the host.
module gcn_class_hist #(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned HIST_W      = 3,
    parameter int unsigned BIN_W       = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              inc_en_i,
    input  logic [BIN_W-1:0]  inc_bin_i,
    input  logic              publish_i,
    output logic [HIST_W-1:0] class_hist_o [0:NUM_CLASSES-1]
);

    logic [HIST_W-1:0] work_q   [0:NUM_CLASSES-1];
    logic [HIST_W-1:0] work_d   [0:NUM_CLASSES-1];
    logic [HIST_W-1:0] work_inc [0:NUM_CLASSES-1];
    logic [HIST_W-1:0] hist_q   [0:NUM_CLASSES-1];
    logic [HIST_W-1:0] hist_d   [0:NUM_CLASSES-1];

    // Publish sees the count including the current beat; clear wins for the working set.
    always_comb begin
        for (int unsigned b = 0; b < NUM_CLASSES; b++) begin
            work_inc[b] = work_q[b];
            if (inc_en_i && (inc_bin_i == BIN_W'(b))) begin
                work_inc[b] = work_q[b] + HIST_W'(1);
            end
            work_d[b] = clear_i   ? '0          : work_inc[b];
            hist_d[b] = publish_i ? work_inc[b] : hist_q[b];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned b = 0; b < NUM_CLASSES; b++) begin
                work_q[b] <= '0;
                hist_q[b] <= '0;
            end
        end else begin
            work_q <= work_d;
            hist_q <= hist_d;
        end
    end

    assign class_hist_o = hist_q;

endmodule

// File: rtl/gcn_result_streamer.sv
// Captures the GCN per-node class vector on done and streams it one node per valid/ready beat.
module gcn_result_streamer
    import gcn_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS      = FEATURE_ROWS_DEF,
    parameter int unsigned MAX_ADDRESS_WIDTH = MAX_ADDRESS_WIDTH_DEF,
    localparam int unsigned NODE_W      = $clog2(FEATURE_ROWS),
    localparam int unsigned NUM_CLASSES = 2 ** MAX_ADDRESS_WIDTH,
    localparam int unsigned HIST_W      = $clog2(FEATURE_ROWS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         done_in,
    input  logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NODE_W-1:0]            out_node,
    output logic [MAX_ADDRESS_WIDTH-1:0] out_class,
    output logic                         out_last,
    output logic                         busy,
    output logic                         frame_done,
    output logic [HIST_W-1:0]            class_hist [0:NUM_CLASSES-1],
    output logic                         overrun
);

    localparam logic [NODE_W-1:0] LAST_IDX = NODE_W'(FEATURE_ROWS - 1);

    stream_state_t                state_q, state_d;
    logic [NODE_W-1:0]            idx_q, idx_d;
    logic [MAX_ADDRESS_WIDTH-1:0] buf_q [0:FEATURE_ROWS-1];
    logic [MAX_ADDRESS_WIDTH-1:0] buf_d [0:FEATURE_ROWS-1];
    logic                         done_prev_q;
    logic                         frame_done_q, frame_done_d;
    logic                         overrun_q, overrun_d;

    logic cap_edge;
    logic is_last;
    logic hist_clear, hist_inc, hist_publish;

    assign cap_edge = done_in & ~done_prev_q;
    assign is_last  = (idx_q == LAST_IDX);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        hist_clear   = 1'b0;
        hist_inc     = 1'b0;
        hist_publish = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_edge) begin
                    buf_d      = max_addi_answer;
                    idx_d      = '0;
                    hist_clear = 1'b1;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    hist_inc = 1'b1;
                    if (!is_last) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        hist_publish = 1'b1;
                        frame_done_d = 1'b1;
                        idx_d        = '0;
                        // A new frame arriving on the final handshake is taken back-to-back.
                        if (cap_edge) begin
                            buf_d      = max_addi_answer;
                            hist_clear = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                if (cap_edge && !(out_ready && is_last)) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            done_prev_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int unsigned i = 0; i < FEATURE_ROWS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            done_prev_q  <= done_in;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            buf_q        <= buf_d;
        end
    end

    gcn_class_hist #(
        .NUM_CLASSES (NUM_CLASSES),
        .HIST_W      (HIST_W),
        .BIN_W       (MAX_ADDRESS_WIDTH)
    ) u_class_hist (
        .clk_i        (clk),
        .rst_ni       (reset),
        .clear_i      (hist_clear),
        .inc_en_i     (hist_inc),
        .inc_bin_i    (buf_q[idx_q]),
        .publish_i    (hist_publish),
        .class_hist_o (class_hist)
    );

    assign busy       = (state_q == STREAM);
    assign out_valid  = busy;
    assign out_node   = busy ? idx_q : '0;
    assign out_class  = busy ? buf_q[idx_q] : '0;
    assign out_last   = busy & is_last;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
